enable_register: RTL and testbench
==================================

Name: enable_register

Overview:
- Parameterisable-width storage register with synchronous load enable and synchronous active-high reset.
- Holds a data word across cycles until explicitly rewritten. Generic building block for capturing settings such as display values, ADC samples and configuration words.
- Also provides two status outputs:
  - a "loaded since reset" flag;
  - a one-cycle "value changed" pulse, for downstream handshaking.

Parameters:
- width, 12, bit width of data and q; legal range 1..64.
- reset_value, all zeros ({width{1'b0}}), value q takes on reset; truncated/zero-extended to width.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset; sampled only on rising clk.
- data  input  width  word to be stored.
- write_enable  input  1  active-high load enable; sampled on rising clk.
- q  output  width  stored word; registered output.
- loaded  output  1  high once at least one write has occurred since the last reset.
- changed  output  1  one-cycle pulse; high in the cycle after a write that altered q.

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-high. Ports are named clk and reset. No asynchronous paths.
- All outputs are registered. No combinational path from any input to any output.
- Reset:
  - On a rising clk edge with reset=1: q <= reset_value, loaded <= 0, changed <= 0.
  - Reset has priority over write_enable; data is ignored in a reset cycle.
  - Reset asserted mid-operation takes effect at the next rising edge regardless of previous state. Holding reset high keeps all outputs at reset values every cycle.
- Load:
  - On a rising edge with reset=0 and write_enable=1: q <= data, loaded <= 1.
  - Latency is 1 clock: q shows the new data immediately after that edge.
- Hold:
  - On a rising edge with reset=0 and write_enable=0: q and loaded retain their values.
  - Any change on data is ignored, including X/Z on data, which must not propagate to q.
- changed:
  - Set to 1 on an edge where reset=0, write_enable=1 and data != current q.
  - Cleared to 0 on every other edge.
  - Back-to-back writes of differing values keep changed high on consecutive cycles.
  - Rewriting the same value gives changed=0.
- Before the first reset, output values are undefined. The bench must apply reset before checking outputs.
- Width rules: data and q are the same width; no sign handling, no arithmetic. Any width in the legal range must synthesise without modification.
- write_enable held high continuously: q tracks data with one-cycle delay (transparent pipeline register).

Test Plan:
1. Reset: width=12; drive reset=1 for 2 cycles -> q=12'h000, loaded=0, changed=0. Release reset -> q stays 12'h000.
2. Hold: reset=0, write_enable=0, data=12'h5A5 for 2 cycles -> q remains 12'h000 (q != data), loaded=0, changed=0.
3. Load: write_enable=1 with data=12'h5A5 -> one edge later q=12'h5A5, loaded=1, changed=1 for exactly one cycle. Then write_enable=0 and data=12'hFFF -> q stays 12'h5A5.
4. Same-value rewrite and back-to-back writes:
   - Write 12'h5A5 again -> q=12'h5A5, changed=0.
   - Then write 12'h123 followed by 12'h456 on consecutive cycles -> q=12'h123 then 12'h456, changed high on both cycles.
5. Reset priority: reset=1 and write_enable=1 with data=12'hABC on the same edge -> q=12'h000, loaded=0, changed=0.
6. Parameter check:
   - Instance with width=8, reset_value=8'hA5: reset -> q=8'hA5; write 8'h3C -> q=8'h3C.
   - Instance with width=1: write 1 -> q=1.

Source files
------------

// File: rtl/enable_register.sv
// Width-parameterised holding register with a synchronous load enable.
// It also provides a "loaded since reset" flag and a one-cycle "value changed" pulse.
module enable_register #(
  parameter int               width       = 12,
  parameter logic [width-1:0] reset_value = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [width-1:0] data,
  input  logic             write_enable,
  output logic [width-1:0] q,
  output logic             loaded,
  output logic             changed
);

  logic differs;

  // Compare against the held word so a same-value rewrite does not pulse changed.
  assign differs = (data != q);

  // Reset wins over write_enable. data is only looked at when a write is requested,
  // so an unknown value on data during a hold cannot reach q.
  always_ff @(posedge clk) begin
    if (reset) begin
      q       <= reset_value;
      loaded  <= 1'b0;
      changed <= 1'b0;
    end else if (write_enable) begin
      q       <= data;
      loaded  <= 1'b1;
      changed <= differs;
    end else begin
      changed <= 1'b0;
    end
  end

endmodule

// File: tb/tb_enable_register.sv
// Directed scoreboard bench for enable_register: 12-bit default, 8-bit with reset 8'hA5, and 1-bit.
// Drivers push expected {q, loaded, changed} words into queues; a monitor pops them and compares.
module tb_enable_register;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_a = 1'b0, we_a = 1'b0, loaded_a, changed_a;
  logic [11:0] data_a = '0, q_a;
  logic        reset_b = 1'b0, we_b = 1'b0, loaded_b, changed_b;
  logic [7:0]  data_b = '0, q_b;
  logic        reset_c = 1'b0, we_c = 1'b0, loaded_c, changed_c;
  logic [0:0]  data_c = '0, q_c;

  enable_register #(.width(12)) dut_a (
    .clk(clk), .reset(reset_a), .data(data_a), .write_enable(we_a),
    .q(q_a), .loaded(loaded_a), .changed(changed_a));

  enable_register #(.width(8), .reset_value(8'hA5)) dut_b (
    .clk(clk), .reset(reset_b), .data(data_b), .write_enable(we_b),
    .q(q_b), .loaded(loaded_b), .changed(changed_b));

  enable_register #(.width(1)) dut_c (
    .clk(clk), .reset(reset_c), .data(data_c), .write_enable(we_c),
    .q(q_c), .loaded(loaded_c), .changed(changed_c));

  // Scoreboard: one expected queue per instance, with a parallel queue of check names.
  logic [13:0] exp_a[$], exp_b[$], exp_c[$];
  string       name_a[$], name_b[$], name_c[$];
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got q=%h loaded=%b changed=%b, expected q=%h loaded=%b changed=%b",
               name, act[13:2], act[1], act[0], exp[13:2], exp[1], exp[0]);
    end
  endtask

  // Monitor: outputs are registered, so each value is sampled on the falling edge after its rising edge.
  always @(negedge clk) begin
    if (exp_a.size() > 0) check(name_a.pop_front(), {q_a, loaded_a, changed_a}, exp_a.pop_front());
    if (exp_b.size() > 0) check(name_b.pop_front(), {4'h0, q_b, loaded_b, changed_b}, exp_b.pop_front());
    if (exp_c.size() > 0) check(name_c.pop_front(), {11'h0, q_c, loaded_c, changed_c}, exp_c.pop_front());
  end

  // Driver: apply one cycle of stimulus to a single instance, then queue the result expected after the edge.
  task automatic step(input int inst, input logic r, input logic w, input logic [11:0] d,
                      input logic [11:0] eq, input logic el, input logic ec, input string name);
    @(negedge clk);
    reset_a = 1'b0; we_a = 1'b0;
    reset_b = 1'b0; we_b = 1'b0;
    reset_c = 1'b0; we_c = 1'b0;
    case (inst)
      0: begin reset_a = r; we_a = w; data_a = d; end
      1: begin reset_b = r; we_b = w; data_b = d[7:0]; end
      default: begin reset_c = r; we_c = w; data_c = d[0:0]; end
    endcase
    @(posedge clk);
    case (inst)
      0: begin exp_a.push_back({eq, el, ec}); name_a.push_back(name); end
      1: begin exp_b.push_back({eq, el, ec}); name_b.push_back(name); end
      default: begin exp_c.push_back({eq, el, ec}); name_c.push_back(name); end
    endcase
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected completion within 100000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 12-bit instance
    step(0, 1, 0, 12'h000, 12'h000, 0, 0, "a_reset_1");
    step(0, 1, 0, 12'h000, 12'h000, 0, 0, "a_reset_2");
    step(0, 0, 0, 12'h000, 12'h000, 0, 0, "a_release");
    step(0, 0, 0, 12'h5A5, 12'h000, 0, 0, "a_hold_1");
    step(0, 0, 0, 12'h5A5, 12'h000, 0, 0, "a_hold_2");
    step(0, 0, 1, 12'h5A5, 12'h5A5, 1, 1, "a_load");
    step(0, 0, 0, 12'hFFF, 12'h5A5, 1, 0, "a_load_pulse_end");
    step(0, 0, 0, 12'hxxx, 12'h5A5, 1, 0, "a_hold_x_data");
    step(0, 0, 1, 12'h5A5, 12'h5A5, 1, 0, "a_same_rewrite");
    step(0, 0, 1, 12'h123, 12'h123, 1, 1, "a_b2b_1");
    step(0, 0, 1, 12'h456, 12'h456, 1, 1, "a_b2b_2");
    step(0, 0, 1, 12'h789, 12'h789, 1, 1, "a_b2b_3");
    step(0, 0, 0, 12'h000, 12'h789, 1, 0, "a_hold_after_b2b");
    step(0, 1, 1, 12'hABC, 12'h000, 0, 0, "a_reset_priority");
    step(0, 1, 0, 12'hDEF, 12'h000, 0, 0, "a_reset_held");
    step(0, 0, 1, 12'h000, 12'h000, 1, 0, "a_write_equal_reset");
    // 8-bit instance, reset value 8'hA5
    step(1, 1, 0, 12'h000, 12'h0A5, 0, 0, "b_reset");
    step(1, 0, 1, 12'h03C, 12'h03C, 1, 1, "b_write");
    step(1, 0, 0, 12'h0FF, 12'h03C, 1, 0, "b_hold");
    step(1, 1, 1, 12'h011, 12'h0A5, 0, 0, "b_reset_priority");
    // 1-bit instance
    step(2, 1, 0, 12'h000, 12'h000, 0, 0, "c_reset");
    step(2, 0, 1, 12'h001, 12'h001, 1, 1, "c_write");
    step(2, 0, 0, 12'h000, 12'h001, 1, 0, "c_hold");
    step(2, 0, 1, 12'h001, 12'h001, 1, 0, "c_same_rewrite");
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_a.size() + exp_b.size() + exp_c.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0",
               exp_a.size() + exp_b.size() + exp_c.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
